// File: rtl/ex_mem_pkg.sv
// Shared EX->MEM definitions: control-bit positions, default widths and payload layout.
// No logic, no latency; the payload packs ctrl in the MSBs so clearing it is a fixed slice.
package ex_mem_pkg;

    localparam int EXMEM_DATA_W = 32;
    localparam int EXMEM_DEST_W = 4;
    localparam int EXMEM_CTRL_W = 3;

    localparam int WB_EN_BIT = 2;
    localparam int MEM_R_BIT = 1;
    localparam int MEM_W_BIT = 0;

    typedef struct packed {
        logic [EXMEM_CTRL_W-1:0] ctrl;
        logic [EXMEM_DATA_W-1:0] alu_res;
        logic [EXMEM_DATA_W-1:0] val_rm;
        logic [EXMEM_DEST_W-1:0] dest;
    } exmem_payload_t;

    localparam int PAYLOAD_W = $bits(exmem_payload_t);

endpackage

// File: rtl/ex_mem_stage_reg_slot.sv
// stage_slot: one payload + valid register with clear (priority), load and hold.
// Latency 1 cycle; no flow control of its own, the parent decides load/clear.
// Clear invalidates and zeroes only the top CLR_W (control) bits; the rest holds.
module stage_slot #(
    parameter int W     = 8,
    parameter int CLR_W = 1
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         load,
    input  logic         clr,
    input  logic [W-1:0] din,
    output logic         vld,
    output logic [W-1:0] dat
);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld <= 1'b0;
            dat <= '0;
        end else if (clr) begin
            vld                <= 1'b0;
            dat[W-1 -: CLR_W]  <= '0;
        end else if (load) begin
            vld <= 1'b1;
            dat <= din;
        end
    end

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX->MEM pipeline register with valid/ready, freeze and flush; EX_MEM_SKID_EN adds a skid slot.
// Latency 1 cycle from accept to outputs; full throughput on simultaneous accept/retire.
// Backpressure: base ready_out = freeze_N & (~valid_out | ready_in); skid ready_out = freeze_N & ~skid_vld.
module ex_mem_stage_reg
    import ex_mem_pkg::*;
#(
    parameter int DATA_W = EXMEM_DATA_W,
    parameter int DEST_W = EXMEM_DEST_W,
    parameter int CTRL_W = EXMEM_CTRL_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              freeze_N,
    input  logic              flush,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] alu_res_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic [DEST_W-1:0] dest_in,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] alu_res_out,
    output logic [DATA_W-1:0] val_rm_out,
    output logic [DEST_W-1:0] dest_out,
    output logic [1:0]        occ
);

    localparam int PW = CTRL_W + 2*DATA_W + DEST_W;

    logic [PW-1:0] in_dat;
    logic [PW-1:0] head_din;
    logic [PW-1:0] head_dat;
    logic          head_vld;
    logic          head_load;
    logic          head_clr;
    logic          accept;
    logic          retire;

    assign in_dat    = {ctrl_in, alu_res_in, val_rm_in, dest_in};
    assign valid_out = head_vld;
    assign accept    = valid_in & ready_out;
    assign retire    = head_vld & ready_in & freeze_N;

`ifdef EX_MEM_SKID_EN
    logic          skid_vld;
    logic          skid_load;
    logic          skid_clr;
    logic [PW-1:0] skid_dat;

    // ready depends only on the skid flop, so ready_in never reaches ready_out
    assign ready_out = freeze_N & ~skid_vld;

    always_comb begin
        head_din  = skid_vld ? skid_dat : in_dat;
        head_load = ~flush & ((~head_vld & accept) | (retire & (skid_vld | accept)));
        head_clr  = flush | (retire & ~skid_vld & ~accept);
        skid_load = ~flush & accept & head_vld & ~retire;
        skid_clr  = flush | (retire & skid_vld);
    end

    stage_slot #(.W(PW), .CLR_W(CTRL_W)) u_skid (
        .CLK   (CLK),
        .RST_N (RST_N),
        .load  (skid_load),
        .clr   (skid_clr),
        .din   (in_dat),
        .vld   (skid_vld),
        .dat   (skid_dat)
    );

    assign occ = {1'b0, head_vld} + {1'b0, skid_vld};
`else
    assign ready_out = freeze_N & (~head_vld | ready_in);
    assign head_din  = in_dat;
    assign head_load = ~flush & accept;
    assign head_clr  = flush | (retire & ~accept);
    assign occ       = {1'b0, head_vld};
`endif

    stage_slot #(.W(PW), .CLR_W(CTRL_W)) u_head (
        .CLK   (CLK),
        .RST_N (RST_N),
        .load  (head_load),
        .clr   (head_clr),
        .din   (head_din),
        .vld   (head_vld),
        .dat   (head_dat)
    );

    assign {ctrl_out, alu_res_out, val_rm_out, dest_out} = head_dat;

endmodule
